// File: rtl/xctcmsg_pkg.sv
// Shared xctcmsg message types for the FU <-> network endpoint path.
package xctcmsg_pkg;
  typedef logic [2:0]  message_addr_t;
  typedef logic [3:0]  message_tag_t;
  typedef logic [15:0] message_data_t;

  typedef struct packed {
    message_addr_t src;
    message_addr_t dst;
    message_tag_t  tag;
    message_data_t data;
  } message_pkt_t;

  localparam int NET_MISROUTE_CNT_W = 16;
endpackage

// File: rtl/bus_interface.sv
// FU <-> NET messaging bus; _o/_i suffixes are from the FU's point of view.
interface bus_interface;
  import xctcmsg_pkg::*;
  logic          bus_val_o;
  logic          bus_ack_i;
  message_addr_t bus_dst_o;
  message_tag_t  bus_tag_o;
  message_data_t bus_msg_o;
  logic          bus_rdy_o;
  logic          bus_val_i;
  message_addr_t bus_src_i;
  message_tag_t  bus_tag_i;
  message_data_t bus_msg_i;

  modport NET (
    input  bus_val_o, bus_dst_o, bus_tag_o, bus_msg_o, bus_rdy_o,
    output bus_ack_i, bus_val_i, bus_src_i, bus_tag_i, bus_msg_i
  );
  modport FU (
    output bus_val_o, bus_dst_o, bus_tag_o, bus_msg_o, bus_rdy_o,
    input  bus_ack_i, bus_val_i, bus_src_i, bus_tag_i, bus_msg_i
  );
endinterface

// File: rtl/msg_fifo.sv
// Registered-head FIFO with wrap-bit pointers; a full FIFO refuses push even when popping.
module msg_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  T            mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/net_endpoint.sv
// Network endpoint: FU sends go to the TX FIFO or loop back to RX; link RX feeds RX or is dropped.
module net_endpoint
  import xctcmsg_pkg::*;
#(
  parameter message_addr_t LOCAL_ADDR = '0,
  parameter int            FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  bus_interface.NET                     bus,
  output logic                          link_tx_val_o,
  input  logic                          link_tx_rdy_i,
  output message_pkt_t                  link_tx_pkt_o,
  input  logic                          link_rx_val_i,
  output logic                          link_rx_rdy_o,
  input  message_pkt_t                  link_rx_pkt_i,
  output logic [NET_MISROUTE_CNT_W-1:0] misroute_cnt_o
);
  logic         active;
  logic         is_local, ack, loop_push, tx_push;
  logic         tx_full, tx_empty, rx_full, rx_empty;
  logic         rx_acc, rx_push, rx_pop, misroute;
  message_pkt_t send_pkt, rx_wdata, rx_head;

  // Holds handshakes off while reset is asserted and until the first edge after release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) active <= 1'b0;
    else         active <= 1'b1;
  end

  assign is_local  = (bus.bus_dst_o == LOCAL_ADDR);
  assign ack       = active && bus.bus_val_o && (is_local ? !rx_full : !tx_full);
  assign loop_push = ack && is_local;
  assign tx_push   = ack && !is_local;
  assign send_pkt  = '{src: LOCAL_ADDR, dst: bus.bus_dst_o, tag: bus.bus_tag_o, data: bus.bus_msg_o};

  // Loopback owns the single RX write port when both want it.
  assign link_rx_rdy_o = active && !rx_full && !loop_push;
  assign rx_acc        = link_rx_val_i && link_rx_rdy_o;
  assign misroute      = rx_acc && (link_rx_pkt_i.dst != LOCAL_ADDR);
  assign rx_push       = loop_push || (rx_acc && !misroute);
  assign rx_wdata      = loop_push ? send_pkt : link_rx_pkt_i;
  assign rx_pop        = !rx_empty && bus.bus_rdy_o;

  assign bus.bus_ack_i = ack;
  assign bus.bus_val_i = !rx_empty;
  assign bus.bus_src_i = rx_head.src;
  assign bus.bus_tag_i = rx_head.tag;
  assign bus.bus_msg_i = rx_head.data;
  assign link_tx_val_o = !tx_empty;

  msg_fifo #(.DEPTH(FIFO_DEPTH), .T(message_pkt_t)) u_tx_fifo (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .push(tx_push), .push_data(send_pkt),
    .pop(link_tx_val_o && link_tx_rdy_i),
    .head(link_tx_pkt_o), .full(tx_full), .empty(tx_empty)
  );

  msg_fifo #(.DEPTH(FIFO_DEPTH), .T(message_pkt_t)) u_rx_fifo (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .push(rx_push), .push_data(rx_wdata),
    .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                         misroute_cnt_o <= '0;
    else if (misroute && !(&misroute_cnt_o)) misroute_cnt_o <= misroute_cnt_o + 1'b1;
  end
endmodule

// File: tb/tb_net_endpoint.sv
// Self-checking bench for net_endpoint: directed table, hand sequences and a queue-based reference model.
module tb_net_endpoint;
  import xctcmsg_pkg::*;
  localparam message_addr_t LA = 3'd0;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bus_interface bus_if ();
  logic         tx_val, tx_rdy, rx_val, rx_rdy;
  message_pkt_t tx_pkt, rx_pkt;
  logic [15:0]  mcnt;

  net_endpoint #(.LOCAL_ADDR(LA), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus_if),
    .link_tx_val_o(tx_val), .link_tx_rdy_i(tx_rdy), .link_tx_pkt_o(tx_pkt),
    .link_rx_val_i(rx_val), .link_rx_rdy_o(rx_rdy), .link_rx_pkt_i(rx_pkt),
    .misroute_cnt_o(mcnt)
  );

  int checks = 0;
  int errors = 0;
  message_pkt_t tx_q[$];
  message_pkt_t rx_q[$];
  int  m_cnt = 0;
  logic m_ack = 1'b0;

  function automatic message_pkt_t mk(input message_addr_t s, input message_addr_t d,
                                      input message_tag_t t, input message_data_t m);
    mk = '{src: s, dst: d, tag: t, data: m};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic fv, input message_addr_t fd, input message_tag_t ft,
                     input message_data_t fm, input logic fr, input logic tr,
                     input logic rv, input message_pkt_t rp);
    bus_if.bus_val_o = fv; bus_if.bus_dst_o = fd; bus_if.bus_tag_o = ft;
    bus_if.bus_msg_o = fm; bus_if.bus_rdy_o = fr;
    tx_rdy = tr; rx_val = rv; rx_pkt = rp;
    #1;
  endtask

  // Reference: two bounded queues and a saturating count, advanced once per cycle.
  task automatic model_check();
    logic loc, e_ack;
    loc   = bus_if.bus_val_o && (bus_if.bus_dst_o == LA);
    e_ack = bus_if.bus_val_o && (loc ? (rx_q.size() < D) : (tx_q.size() < D));
    chk("ack", 64'(bus_if.bus_ack_i), 64'(e_ack));
    chk("link_rx_rdy", 64'(rx_rdy), 64'((rx_q.size() < D) && !(e_ack && loc)));
    chk("tx_val", 64'(tx_val), 64'(tx_q.size() != 0));
    if (tx_q.size() != 0) chk("tx_pkt", 64'(tx_pkt), 64'(tx_q[0]));
    chk("bus_val", 64'(bus_if.bus_val_i), 64'(rx_q.size() != 0));
    if (rx_q.size() != 0)
      chk("bus_head", 64'({bus_if.bus_src_i, bus_if.bus_tag_i, bus_if.bus_msg_i}),
          64'({rx_q[0].src, rx_q[0].tag, rx_q[0].data}));
    chk("misroute_cnt", 64'(mcnt), 64'(m_cnt));
  endtask

  task automatic model_update();
    logic loc, rrdy, ptx, prx;
    message_pkt_t sp;
    loc   = bus_if.bus_dst_o == LA;
    m_ack = bus_if.bus_val_o && (loc ? (rx_q.size() < D) : (tx_q.size() < D));
    rrdy  = (rx_q.size() < D) && !(m_ack && loc);
    ptx   = (tx_q.size() != 0) && tx_rdy;
    prx   = (rx_q.size() != 0) && bus_if.bus_rdy_o;
    sp    = mk(LA, bus_if.bus_dst_o, bus_if.bus_tag_o, bus_if.bus_msg_o);
    if (ptx) void'(tx_q.pop_front());
    if (prx) void'(rx_q.pop_front());
    if (m_ack && !loc) tx_q.push_back(sp);
    if (m_ack && loc) rx_q.push_back(sp);
    else if (rx_val && rrdy) begin
      if (rx_pkt.dst == LA) rx_q.push_back(rx_pkt);
      else if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic step();
    model_check();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input logic fr, input logic tr);
    drv(1'b0, 3'd0, 4'd0, 16'h0, fr, tr, 1'b0, mk(0, 0, 0, 0));
  endtask

  task automatic model_clear();
    tx_q.delete(); rx_q.delete(); m_cnt = 0; m_ack = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(1'b0, 1'b0);
    chk("rst_ack", 64'(bus_if.bus_ack_i), 64'(0));
    chk("rst_bus_val", 64'(bus_if.bus_val_i), 64'(0));
    chk("rst_tx_val", 64'(tx_val), 64'(0));
    chk("rst_rx_rdy", 64'(rx_rdy), 64'(0));
    chk("rst_cnt", 64'(mcnt), 64'(0));
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic fv; message_addr_t fd; message_tag_t ft; message_data_t fm;
    logic fr, tr, rv; message_pkt_t rp;
    logic e_ack, e_rrdy, e_txv; message_pkt_t e_txp;
    logic e_bv; message_addr_t e_src; message_tag_t e_btag; message_data_t e_bd;
  } vec_t;
  vec_t tbl[8];

  logic          pend, fv;
  message_addr_t fd;
  message_tag_t  ft;
  message_data_t fm;

  initial begin
    message_pkt_t p0, pl, pm;
    p0 = mk(0, 0, 0, 0);
    pl = mk(3'd5, 3'd0, 4'd3, 16'h2222);
    tbl[0] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, p0, 1'b0, 1'b1, 1'b0, p0, 1'b0, 3'd0, 4'd0, 16'h0};
    tbl[1] = '{1'b1, 3'd3, 4'd1, 16'hDEAD, 1'b0, 1'b1, 1'b0, p0, 1'b1, 1'b1, 1'b0, p0, 1'b0, 3'd0, 4'd0, 16'h0};
    tbl[2] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b0, 1'b1, 1'b0, p0, 1'b0, 1'b1, 1'b1, mk(0, 3, 1, 16'hDEAD),
               1'b0, 3'd0, 4'd0, 16'h0};
    tbl[3] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b0, 1'b1, 1'b0, p0, 1'b0, 1'b1, 1'b0, p0, 1'b0, 3'd0, 4'd0, 16'h0};
    tbl[4] = '{1'b1, 3'd0, 4'd2, 16'h1111, 1'b0, 1'b1, 1'b1, pl, 1'b1, 1'b0, 1'b0, p0, 1'b0, 3'd0, 4'd0, 16'h0};
    tbl[5] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b1, 1'b1, 1'b1, pl, 1'b0, 1'b1, 1'b0, p0, 1'b1, 3'd0, 4'd2, 16'h1111};
    tbl[6] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b1, 1'b1, 1'b0, pl, 1'b0, 1'b1, 1'b0, p0, 1'b1, 3'd5, 4'd3, 16'h2222};
    tbl[7] = '{1'b0, 3'd0, 4'd0, 16'h0,    1'b1, 1'b1, 1'b0, p0, 1'b0, 1'b1, 1'b0, p0, 1'b0, 3'd0, 4'd0, 16'h0};

    @(negedge clk);
    do_reset();

    // Remote send and loopback-priority vectors.
    for (int i = 0; i < 8; i++) begin
      drv(tbl[i].fv, tbl[i].fd, tbl[i].ft, tbl[i].fm, tbl[i].fr, tbl[i].tr, tbl[i].rv, tbl[i].rp);
      chk($sformatf("tbl%0d_ack", i), 64'(bus_if.bus_ack_i), 64'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_rrdy", i), 64'(rx_rdy), 64'(tbl[i].e_rrdy));
      chk($sformatf("tbl%0d_txv", i), 64'(tx_val), 64'(tbl[i].e_txv));
      chk($sformatf("tbl%0d_bv", i), 64'(bus_if.bus_val_i), 64'(tbl[i].e_bv));
      if (tbl[i].e_txv) chk($sformatf("tbl%0d_txp", i), 64'(tx_pkt), 64'(tbl[i].e_txp));
      if (tbl[i].e_bv)
        chk($sformatf("tbl%0d_head", i), 64'({bus_if.bus_src_i, bus_if.bus_tag_i, bus_if.bus_msg_i}),
            64'({tbl[i].e_src, tbl[i].e_btag, tbl[i].e_bd}));
      step();
    end

    // TX backpressure: 4 acks into a stalled link, 5th waits.
    do_reset();
    begin
      int k = 0;
      for (int i = 0; i < 5; i++) begin
        drv(1'b1, 3'd3, 4'd0, 16'h100 + 16'(k), 1'b0, 1'b0, 1'b0, p0);
        chk("txbp_ack", 64'(bus_if.bus_ack_i), 64'(i < 4));
        if (bus_if.bus_ack_i) k++;
        step();
      end
    end
    drv(1'b1, 3'd3, 4'd0, 16'h104, 1'b0, 1'b1, 1'b0, p0);
    chk("txbp_full_ack", 64'(bus_if.bus_ack_i), 64'(0));
    chk("txbp_d0", 64'(tx_pkt.data), 64'(16'h100));
    step();
    drv(1'b1, 3'd3, 4'd0, 16'h104, 1'b0, 1'b1, 1'b0, p0);
    chk("txbp_ack5", 64'(bus_if.bus_ack_i), 64'(1));
    chk("txbp_d1", 64'(tx_pkt.data), 64'(16'h101));
    step();
    for (int j = 2; j < 5; j++) begin
      idle(1'b0, 1'b1);
      chk("txbp_val", 64'(tx_val), 64'(1));
      chk("txbp_dj", 64'(tx_pkt.data), 64'(16'h100 + j));
      step();
    end
    idle(1'b0, 1'b1);
    chk("txbp_drained", 64'(tx_val), 64'(0));
    step();

    // RX full: link fills RX, then a single pop frees one slot.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 16'h300 + 16'(i)));
      chk("rxf_rdy", 64'(rx_rdy), 64'(1));
      step();
    end
    drv(1'b1, 3'd0, 4'd0, 16'h3AA, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 16'h304));
    chk("rxf_rdy_full", 64'(rx_rdy), 64'(0));
    chk("rxf_ack_full", 64'(bus_if.bus_ack_i), 64'(0));
    step();
    drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 16'h304));
    chk("rxf_pop_rdy", 64'(rx_rdy), 64'(0));
    chk("rxf_head", 64'(bus_if.bus_msg_i), 64'(16'h300));
    step();
    drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 16'h304));
    chk("rxf_rdy_back", 64'(rx_rdy), 64'(1));
    step();

    // Reset mid-traffic with both FIFOs half full and a nonzero counter.
    do_reset();
    drv(1'b1, 3'd3, 4'd0, 16'h500, 1'b0, 1'b0, 1'b0, p0); step();
    drv(1'b1, 3'd3, 4'd0, 16'h501, 1'b0, 1'b0, 1'b1, mk(1, 7, 0, 0)); step();
    drv(1'b1, 3'd0, 4'd0, 16'h502, 1'b0, 1'b0, 1'b0, p0); step();
    drv(1'b1, 3'd0, 4'd0, 16'h503, 1'b0, 1'b0, 1'b0, p0); step();
    drv(1'b1, 3'd3, 4'd0, 16'h504, 1'b0, 1'b0, 1'b0, p0);
    chk("mid_cnt", 64'(mcnt), 64'(1));
    chk("mid_ack_pre", 64'(bus_if.bus_ack_i), 64'(1));
    #2 rstn = 1'b0;
    #1;
    chk("mid_ack", 64'(bus_if.bus_ack_i), 64'(0));
    chk("mid_bus_val", 64'(bus_if.bus_val_i), 64'(0));
    chk("mid_tx_val", 64'(tx_val), 64'(0));
    chk("mid_cnt0", 64'(mcnt), 64'(0));
    model_clear();
    repeat (2) @(negedge clk);
    idle(1'b1, 1'b1);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1'b1);
      chk("post_tx_val", 64'(tx_val), 64'(0));
      chk("post_bus_val", 64'(bus_if.bus_val_i), 64'(0));
      step();
    end

    // Random traffic against the reference model; FU holds its request until acked.
    do_reset();
    pend = 1'b0; fv = 1'b0; fd = '0; ft = '0; fm = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!pend) begin
        fv = 1'($urandom_range(0, 1));
        fd = ($urandom_range(0, 2) == 0) ? LA : 3'($urandom_range(0, 7));
        ft = 4'($urandom);
        fm = 16'($urandom);
      end
      pm = mk(3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : LA, 4'($urandom), 16'($urandom));
      drv(fv, fd, ft, fm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), pm);
      step();
      pend = fv && !m_ack;
    end

    // Misroutes, then saturation of the counter.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b1, 1'b1, 1'b1, mk(2, 7, 1, 16'h77));
      chk("mis_rdy", 64'(rx_rdy), 64'(1));
      chk("mis_bus_val", 64'(bus_if.bus_val_i), 64'(0));
      step();
    end
    chk("mis_cnt3", 64'(mcnt), 64'(3));
    chk("mis_no_deliver", 64'(bus_if.bus_val_i), 64'(0));
    for (int i = 0; i < 65532; i++) begin
      drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b1, 1'b1, 1'b1, mk(2, 7, 1, 16'h77));
      step();
    end
    chk("mis_cnt_max", 64'(mcnt), 64'(16'hFFFF));
    drv(1'b0, 3'd0, 4'd0, 16'h0, 1'b1, 1'b1, 1'b1, mk(2, 7, 1, 16'h77));
    step();
    chk("mis_cnt_sat", 64'(mcnt), 64'(16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
